// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory request/response bus between fetch stage and imem
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with one outstanding imem request and IF/ID register
module if_fetch_stage #(
    parameter logic [31:0] BUBBLE_INSTR = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               pc_in,
    input  logic                      stall_in,
    input  logic                      flush_in,
    if_fetch_stage_if.master          imem,
    output logic                      pc_enable,
    output logic                      if_id_valid,
    output logic [31:0]               if_id_pc,
    output logic [31:0]               if_id_pc_plus4,
    output logic [31:0]               if_id_instr
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state;
    logic [31:0] req_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic [31:0] instr_q;

    // Request/enable must react to imem_ready and flush in the same cycle, so they stay combinational.
    assign imem.imem_req  = !reset && !flush_in && (state == S_REQ);
    assign imem.imem_addr = pc_in;
    assign pc_enable      = !reset && (flush_in || ((state == S_REQ) && imem.imem_ready));
    assign if_id_instr    = if_id_valid ? instr_q : BUBBLE_INSTR;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_REQ;
            req_pc         <= 32'd0;
            skid_pc        <= 32'd0;
            skid_instr     <= 32'd0;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            instr_q        <= BUBBLE_INSTR;
        end else if (flush_in) begin
            if_id_valid <= 1'b0;
            skid_pc     <= 32'd0;
            skid_instr  <= 32'd0;
            // An outstanding request whose response has not yet arrived must be drained.
            if ((state == S_WAIT) || (state == S_DRAIN)) begin
                state <= imem.imem_rvalid ? S_REQ : S_DRAIN;
            end else begin
                state <= S_REQ;
            end
        end else begin
            if (!stall_in) begin
                if_id_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem.imem_ready) begin
                        req_pc <= pc_in;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!stall_in) begin
                            if_id_valid    <= 1'b1;
                            if_id_pc       <= req_pc;
                            if_id_pc_plus4 <= req_pc + 32'd4;
                            instr_q        <= imem.imem_rdata;
                            state          <= S_REQ;
                        end else begin
                            skid_pc    <= req_pc;
                            skid_instr <= imem.imem_rdata;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_in) begin
                        if_id_valid    <= 1'b1;
                        if_id_pc       <= skid_pc;
                        if_id_pc_plus4 <= skid_pc + 32'd4;
                        instr_q        <= skid_instr;
                        state          <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;
    localparam logic [31:0] BUBBLE = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        stall_in;
    logic        flush_in;
    logic        pc_enable;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    int          checks;
    int          errors;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.BUBBLE_INSTR(BUBBLE)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .imem           (bus.master),
        .pc_enable      (pc_enable),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", bus.imem_req); end
        checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL rst_pc_en: got %b exp 0", pc_enable); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", if_id_valid); end
        checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h exp 0", if_id_pc); end
        checks++; if (if_id_pc_plus4 !== 32'd0) begin errors++; $display("FAIL rst_pc4: got %h exp 0", if_id_pc_plus4); end
        checks++; if (if_id_instr !== BUBBLE) begin errors++; $display("FAIL rst_instr: got %h exp %h", if_id_instr, BUBBLE); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        pc_in = 32'h0;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL zw_req0: got %b exp 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL zw_addr0: got %h exp 0", bus.imem_addr); end
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL zw_pcen0: got %b exp 1", pc_enable); end
        tick();
        pc_in = 32'h4; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00500093;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL zw_wait_req: got %b exp 0", bus.imem_req); end
        checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL zw_wait_pcen: got %b exp 0", pc_enable); end
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr} !== {1'b1, 32'h0, 32'h4, 32'h00500093})
            begin errors++; $display("FAIL zw_ifid0: got %b %h %h %h exp 1 0 4 00500093", if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr); end
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL zw_addr1: got %h exp 4", bus.imem_addr); end
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL zw_pcen1: got %b exp 1", pc_enable); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL zw_bubble: got %b exp 0", if_id_valid); end
        checks++; if (if_id_instr !== BUBBLE) begin errors++; $display("FAIL zw_bubble_instr: got %h exp %h", if_id_instr, BUBBLE); end
        pc_in = 32'h8; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00100113;
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr} !== {1'b1, 32'h4, 32'h8, 32'h00100113})
            begin errors++; $display("FAIL zw_ifid1: got %b %h %h %h exp 1 4 8 00100113", if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr); end
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        #1;
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL st_pcen: got %b exp 1", pc_enable); end
        tick();
        pc_in = 32'hC; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00200193;
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h4, 32'h00100113})
            begin errors++; $display("FAIL st_held: got %b %h %h exp 1 4 00100113", if_id_valid, if_id_pc, if_id_instr); end
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if ({bus.imem_req, pc_enable} !== 2'b00) begin errors++; $display("FAIL st_hold_req1: got %b%b exp 00", bus.imem_req, pc_enable); end
        tick();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL st_hold_req2: got %b exp 0", bus.imem_req); end
        checks++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h4}) begin errors++; $display("FAIL st_held2: got %b %h exp 1 4", if_id_valid, if_id_pc); end
        tick();
        bus.imem_rvalid = 1'b0; stall_in = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL st_hold_req3: got %b exp 0", bus.imem_req); end
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr} !== {1'b1, 32'h8, 32'hC, 32'h00200193})
            begin errors++; $display("FAIL st_release: got %b %h %h %h exp 1 8 c 00200193", if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr); end
    endtask

    task automatic test_flush_wait();
        stall_in = 1'b1;
        #1;
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL fl_accept: got %b exp 1", pc_enable); end
        tick();
        checks++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h8}) begin errors++; $display("FAIL fl_pre: got %b %h exp 1 8", if_id_valid, if_id_pc); end
        stall_in = 1'b0; flush_in = 1'b1;
        #1;
        checks++; if ({bus.imem_req, pc_enable} !== 2'b01) begin errors++; $display("FAIL fl_cycle: req/pcen got %b%b exp 01", bus.imem_req, pc_enable); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b exp 0", if_id_valid); end
        checks++; if (if_id_instr !== BUBBLE) begin errors++; $display("FAIL fl_instr: got %h exp %h", if_id_instr, BUBBLE); end
        flush_in = 1'b0; pc_in = 32'h100;
        #1;
        checks++; if ({bus.imem_req, pc_enable} !== 2'b00) begin errors++; $display("FAIL fl_drain1: got %b%b exp 00", bus.imem_req, pc_enable); end
        tick();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0BAD0BAD;
        #1;
        checks++; if ({bus.imem_req, pc_enable} !== 2'b00) begin errors++; $display("FAIL fl_drain2: got %b%b exp 00", bus.imem_req, pc_enable); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL fl_discard: got %b exp 0", if_id_valid); end
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if ({bus.imem_req, bus.imem_addr, pc_enable} !== {1'b1, 32'h100, 1'b1})
            begin errors++; $display("FAIL fl_newreq: got %b %h %b exp 1 100 1", bus.imem_req, bus.imem_addr, pc_enable); end
        tick();
        pc_in = 32'h104; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000033;
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h100, 32'h00000033})
            begin errors++; $display("FAIL fl_target: got %b %h %h exp 1 100 00000033", if_id_valid, if_id_pc, if_id_instr); end
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({bus.imem_req, bus.imem_addr, pc_enable} !== {1'b1, 32'h104, 1'b0})
                begin errors++; $display("FAIL bp_cycle%0d: got %b %h %b exp 1 104 0", i, bus.imem_req, bus.imem_addr, pc_enable); end
            tick();
        end
        bus.imem_ready = 1'b1;
        #1;
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b exp 1", pc_enable); end
        tick();
        pc_in = 32'h108; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00308213;
        #1;
        checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL bp_single_pulse: got %b exp 0", pc_enable); end
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h104, 32'h00308213})
            begin errors++; $display("FAIL bp_ifid: got %b %h %h exp 1 104 00308213", if_id_valid, if_id_pc, if_id_instr); end
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        tick();
        reset = 1'b1;
        #1;
        checks++; if ({bus.imem_req, pc_enable} !== 2'b00) begin errors++; $display("FAIL rw_inreset: got %b%b exp 00", bus.imem_req, pc_enable); end
        tick();
        checks++; if ({if_id_valid, if_id_pc} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rw_cleared: got %b %h exp 0 0", if_id_valid, if_id_pc); end
        reset = 1'b0; pc_in = 32'h200; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h11111111;
        #1;
        checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL rw_state_req: got %b %h exp 1 200", bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rw_stale: got %b exp 0", if_id_valid); end
        bus.imem_rdata = 32'h22222222;
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h200, 32'h22222222})
            begin errors++; $display("FAIL rw_refetch: got %b %h %h exp 1 200 22222222", if_id_valid, if_id_pc, if_id_instr); end
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_wrap();
        pc_in = 32'hFFFFFFFC;
        #1;
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b exp 1", pc_enable); end
        tick();
        pc_in = 32'h0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000073;
        tick();
        checks++; if ({if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr} !== {1'b1, 32'hFFFFFFFC, 32'h0, 32'h00000073})
            begin errors++; $display("FAIL wr_ifid: got %b %h %h %h exp 1 fffffffc 0 73", if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr); end
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        pc_in = 32'h0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_flush_wait();
        test_backpressure();
        test_reset_mid_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter BUBBLE_INSTR, default 32'h00000013, SHALL be the instruction value driven on if_id_instr whenever if_id_valid=0.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 pc_in  input  32  SHALL be the current PC from the PC-update stage.
REQ-005 stall_in  input  1  SHALL indicate the decode stage cannot accept a new IF/ID entry this cycle.
REQ-006 flush_in  input  1  SHALL indicate a taken branch or jump; all in-flight fetch work is squashed.
REQ-007 imem_ready  input  1  SHALL indicate instruction memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  SHALL indicate imem_rdata carries the response to the outstanding request.
REQ-009 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-010 imem_req  output  1  SHALL request a fetch at imem_addr.
REQ-011 imem_addr  output  32  SHALL be the fetch address, equal to pc_in.
REQ-012 pc_enable  output  1  SHALL be the enable to the PC-update stage (advance or load target).
REQ-013 if_id_valid  output  1  SHALL mark the IF/ID entry as a real instruction.
REQ-014 if_id_pc  output  32  SHALL be the address of the IF/ID instruction.
REQ-015 if_id_pc_plus4  output  32  SHALL be if_id_pc+4, modulo 2^32.
REQ-016 if_id_instr  output  32  SHALL be the IF/ID instruction word.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, DRAIN, with at most one memory request outstanding.
REQ-018 REQ: imem_req=1 and imem_addr=pc_in when flush_in=0; on imem_ready=1, the block SHALL latch pc_in as req_pc, assert pc_enable for that cycle, and go to WAIT.
REQ-019 REQ with imem_ready=0: stay in REQ, pc_enable=0, and hold imem_addr stable while pc_in is stable.
REQ-020 WAIT with imem_rvalid=1 and stall_in=0: load IF/ID with {1, req_pc, req_pc+4, imem_rdata} on the next edge and go to REQ.
REQ-021 WAIT with imem_rvalid=1 and stall_in=1: capture {req_pc, imem_rdata} into a one-entry skid buffer, leave IF/ID unchanged, and go to HOLD.
REQ-022 HOLD: imem_req=0; when stall_in=0, move the skid buffer into IF/ID (valid=1) and go to REQ.
REQ-023 IF/ID SHALL hold its contents while stall_in=1 and flush_in=0.
REQ-024 With stall_in=0 and no new entry loaded that cycle, if_id_valid SHALL clear to 0 (bubble).
REQ-025 flush_in=1 takes priority over all other inputs, with these effects:
- imem_req=0 that cycle
- pc_enable=1 so the PC loads the target
- if_id_valid<=0
- skid buffer discarded
REQ-026 flush_in=1 in the remaining states SHALL act as follows:
- WAIT with no rvalid that cycle: go to DRAIN
- WAIT with rvalid that cycle: discard the response and go to REQ
- HOLD or REQ: go to REQ
REQ-027 DRAIN: imem_req=0 and pc_enable=0; the next imem_rvalid response SHALL be discarded, then the FSM goes to REQ.
REQ-028 imem_rvalid in REQ or HOLD SHALL be ignored.
REQ-029 if_id_instr SHALL read BUBBLE_INSTR whenever if_id_valid=0, independent of the stored word.
REQ-030 Best-case throughput SHALL be one instruction per two cycles (REQ then WAIT with rvalid on the next cycle).

Reset
REQ-031 With reset=1 at a rising edge, the following SHALL hold on the next cycle:
- state=REQ
- if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=BUBBLE_INSTR
- skid buffer cleared
REQ-032 While reset=1: imem_req=0 and pc_enable=0.
REQ-033 Reset asserted in WAIT or DRAIN SHALL abandon the outstanding request; a late imem_rvalid after reset is released SHALL be ignored, because state is REQ.

Verification
REQ-034 Zero-wait memory:
- Stimulus: pc_in=0x0, then 0x4; imem_ready=1; rvalid one cycle after each request; rdata=0x00500093, then 0x00100113.
- Response: IF/ID holds {1,0x0,0x4,0x00500093}, then {1,0x4,0x8,0x00100113}; pc_enable pulses once per fetch.
REQ-035 Stall on return:
- Stimulus: stall_in=1 in the rvalid cycle for pc 0x8, released 3 cycles later.
- Response: IF/ID unchanged during the stall; after release, IF/ID={1,0x8,0xC,rdata}; no request issued while in HOLD.
REQ-036 Flush in WAIT:
- Stimulus: flush_in=1 one cycle after request acceptance; rvalid arrives 2 cycles later.
- Response: pc_enable=1 in the flush cycle; if_id_valid=0; response discarded; the next request goes to the new pc_in.
REQ-037 Memory backpressure:
- Stimulus: imem_ready=0 for 4 cycles.
- Response: imem_req held at 1, imem_addr stable, pc_enable=0 throughout; exactly one pc_enable pulse on acceptance.
REQ-038 Reset mid-WAIT:
- Stimulus: reset=1 for one cycle while in WAIT; rvalid arrives after reset is released.
- Response: state=REQ and if_id_valid=0; the stale rvalid is ignored.
REQ-039 Wrap-around:
- Stimulus: fetch with pc_in=0xFFFFFFFC.
- Response: if_id_pc_plus4=0x00000000.
